viterbi_ber_checker: RTL and testbench
======================================

Name: viterbi_ber_checker

Overview:
Receive-side bit-error-rate checker for the Viterbi link. It sits after the decoder in the tx/rx harness and keeps a history of source bits fed to the encoder. It finds the decoder's latency by sliding correlation, then counts decoded bits and bit errors against the aligned source stream. It is the measuring end of the error-injection channel: injected channel errors go in, residual post-decode errors come out.

Parameters:
MAX_LAT, 64, source history depth in bits; power of 2, at least 2; maximum decoder latency that can be searched
LOCK_RUN, 16, consecutive matches required to declare lock
WIN, 64, loss-of-lock window length in compared bits
LOSS_ERR, 8, errors within one window that force loss of lock
CNT_W, 32, width of the bit and error counters

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
src_valid_i  input  1  source bit strobe (same as encoder enable)
src_bit_i  input  1  source bit (encoder input)
dec_valid_i  input  1  decoded bit strobe
dec_bit_i  input  1  decoded bit
clear_i  input  1  synchronous clear of statistics
state_o  output  2  current state (chk_state_t)
locked_o  output  1  high in LOCKED
lat_o  output  $clog2(MAX_LAT)  current latency hypothesis
bit_ct_o  output  CNT_W  bits compared while LOCKED
err_ct_o  output  CNT_W  mismatches while LOCKED
relock_ct_o  output  8  LOCKED->SEARCH transitions, saturating
err_o  output  1  one-cycle pulse per LOCKED mismatch

Behaviour:
- Decided interface rule: one clock (clk); reset rst is synchronous and active-high; it is sampled only at posedge clk.
- Reset: state IDLE; all outputs 0; history, fill, run and window counters 0.
- Source and decoded streams advance at equal rate; the offset between them is constant once the decoder is filled.
- History: hist[0] is the newest source bit. On src_valid_i, hist shifts up and src_bit_i enters hist[0].
- A compare uses hist[lat] before any shift in the same cycle. A decoded bit equal to the source bit D pulses earlier aligns at lat = D-1.
- IDLE: count src_valid_i pulses up to MAX_LAT. Ignore dec_valid_i. When the fill count reaches MAX_LAT, go to SEARCH with lat=0.
- SEARCH, on each dec_valid_i:
  - match: run++. If run reaches LOCK_RUN, go to LOCKED and clear the window counters.
  - mismatch: run=0; lat = lat+1, wrapping MAX_LAT-1 to 0.
  - Statistics do not count in SEARCH.
- LOCKED, on each dec_valid_i:
  - bit_ct++.
  - mismatch: err_ct++, err_o=1 on the next cycle, win_err++.
  - win_cnt++. At win_cnt==WIN, clear win_cnt and win_err.
  - If win_err reaches LOSS_ERR: go to SEARCH, run=0, lat=lat+1 (wrapping), relock_ct++. Counters keep their values.
- Latency: outputs are registered. A compare on cycle t is visible on cycle t+1.
- Counters saturate at all-ones and never wrap.
- clear_i: zeroes bit_ct, err_ct, relock_ct, win_cnt and win_err. State and lat are unchanged. clear_i has priority over a compare in the same cycle; that compare is not counted.
- rst mid-operation behaves exactly like power-on reset, including emptying the history.
- dec_valid_i in the same cycle as a SEARCH->LOCKED transition belongs to SEARCH.

Decomposition:
- Shared package viterbi_pkg:
  - chk_state_t enum {IDLE=0, SEARCH=1, LOCKED=2}
  - default constants CHK_MAX_LAT, CHK_LOCK_RUN, CHK_WIN, CHK_LOSS_ERR
- One sub-module, ber_src_history: MAX_LAT-bit shift register with shift enable and index-select read port.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> state_o=0, all counters 0, err_o=0, locked_o=0.
- Lock: continuous strobes, random source, decoder = source delayed D=37 -> LOCKED after fill plus search; lat_o=36; err_ct_o=0; bit_ct_o increments once per cycle.
- Errors without loss: while LOCKED, invert 3 decoded bits spaced 10 apart -> err_ct_o=3, three isolated err_o pulses, locked_o stays 1.
- Loss and relock: invert 8 decoded bits within one 64-bit window -> SEARCH on the cycle after the 8th error; relock_ct_o=1; relock at lat_o=36; err_ct_o=8 retained.
- clear_i in the same cycle as an error -> next cycle bit_ct_o=0 and err_ct_o=0; state stays LOCKED.
- Saturation (CNT_W=8): lock, run 300 compares -> bit_ct_o=255 and holds. Then rst mid-stream -> next cycle IDLE with all outputs 0.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and default constants for the Viterbi link BER checker.
package viterbi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam int unsigned CHK_MAX_LAT  = 64;
    localparam int unsigned CHK_LOCK_RUN = 16;
    localparam int unsigned CHK_WIN      = 64;
    localparam int unsigned CHK_LOSS_ERR = 8;

endpackage

// File: rtl/ber_src_history.sv
// Source-bit history: shift register with the newest bit at index 0 and an
// index-select read port.
module ber_src_history #(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_shift,
    input  logic                     i_bit,
    input  logic [$clog2(DEPTH)-1:0] i_sel,
    output logic                     o_bit
);

    logic [DEPTH-1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
        end else if (i_shift) begin
            r_hist <= {r_hist[DEPTH-2:0], i_bit};
        end
    end

    // Read sees the history before any shift in the same cycle.
    assign o_bit = r_hist[i_sel];

endmodule

// File: rtl/viterbi_ber_checker.sv
// Receive-side BER checker: finds decoder latency by sliding correlation,
// then counts compared bits and residual errors against the source stream.
module viterbi_ber_checker
    import viterbi_pkg::*;
#(
    parameter int unsigned MAX_LAT  = CHK_MAX_LAT,
    parameter int unsigned LOCK_RUN = CHK_LOCK_RUN,
    parameter int unsigned WIN      = CHK_WIN,
    parameter int unsigned LOSS_ERR = CHK_LOSS_ERR,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       src_valid_i,
    input  logic                       src_bit_i,
    input  logic                       dec_valid_i,
    input  logic                       dec_bit_i,
    input  logic                       clear_i,
    output logic [1:0]                 state_o,
    output logic                       locked_o,
    output logic [$clog2(MAX_LAT)-1:0] lat_o,
    output logic [CNT_W-1:0]           bit_ct_o,
    output logic [CNT_W-1:0]           err_ct_o,
    output logic [7:0]                 relock_ct_o,
    output logic                       err_o
);

    localparam int unsigned LW = $clog2(MAX_LAT);
    localparam int unsigned FW = $clog2(MAX_LAT + 1);
    localparam int unsigned RW = $clog2(LOCK_RUN + 1);
    localparam int unsigned WW = $clog2(WIN + 1);
    localparam int unsigned EW = $clog2(LOSS_ERR + 1);

    chk_state_t       r_state, w_state_d;
    logic [LW-1:0]    r_lat, w_lat_d;
    logic [FW-1:0]    r_fill, w_fill_d;
    logic [RW-1:0]    r_run, w_run_d;
    logic [WW-1:0]    r_win_cnt, w_win_cnt_d;
    logic [EW-1:0]    r_win_err, w_win_err_d;
    logic [CNT_W-1:0] r_bit_ct, w_bit_ct_d;
    logic [CNT_W-1:0] r_err_ct, w_err_ct_d;
    logic [7:0]       r_relock_ct, w_relock_ct_d;
    logic             r_err, w_err_d;

    logic             w_hist_bit;
    logic             w_cmp;
    logic             w_match;
    logic [EW-1:0]    w_win_err_inc;

    ber_src_history #(
        .DEPTH (MAX_LAT)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .i_shift (src_valid_i),
        .i_bit   (src_bit_i),
        .i_sel   (r_lat),
        .o_bit   (w_hist_bit)
    );

    // A clear suppresses the whole compare of that cycle, not just its counting.
    assign w_cmp         = dec_valid_i && !clear_i;
    assign w_match       = (dec_bit_i == w_hist_bit);
    assign w_win_err_inc = r_win_err + EW'(!w_match);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lat       <= '0;
            r_fill      <= '0;
            r_run       <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_bit_ct    <= '0;
            r_err_ct    <= '0;
            r_relock_ct <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_lat       <= w_lat_d;
            r_fill      <= w_fill_d;
            r_run       <= w_run_d;
            r_win_cnt   <= w_win_cnt_d;
            r_win_err   <= w_win_err_d;
            r_bit_ct    <= w_bit_ct_d;
            r_err_ct    <= w_err_ct_d;
            r_relock_ct <= w_relock_ct_d;
            r_err       <= w_err_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_lat_d       = r_lat;
        w_fill_d      = r_fill;
        w_run_d       = r_run;
        w_win_cnt_d   = r_win_cnt;
        w_win_err_d   = r_win_err;
        w_bit_ct_d    = r_bit_ct;
        w_err_ct_d    = r_err_ct;
        w_relock_ct_d = r_relock_ct;
        w_err_d       = 1'b0;

        if (clear_i) begin
            w_bit_ct_d    = '0;
            w_err_ct_d    = '0;
            w_relock_ct_d = '0;
            w_win_cnt_d   = '0;
            w_win_err_d   = '0;
        end

        unique case (r_state)
            IDLE: begin
                if (src_valid_i) begin
                    w_fill_d = r_fill + FW'(1);
                    if (r_fill == FW'(MAX_LAT - 1)) begin
                        w_state_d = SEARCH;
                        w_lat_d   = '0;
                    end
                end
            end
            SEARCH: begin
                if (w_cmp) begin
                    if (w_match) begin
                        if (r_run == RW'(LOCK_RUN - 1)) begin
                            w_state_d   = LOCKED;
                            w_run_d     = '0;
                            w_win_cnt_d = '0;
                            w_win_err_d = '0;
                        end else begin
                            w_run_d = r_run + RW'(1);
                        end
                    end else begin
                        w_run_d = '0;
                        w_lat_d = r_lat + LW'(1);
                    end
                end
            end
            LOCKED: begin
                if (w_cmp) begin
                    w_bit_ct_d = (&r_bit_ct) ? r_bit_ct : r_bit_ct + CNT_W'(1);
                    if (!w_match) begin
                        w_err_ct_d = (&r_err_ct) ? r_err_ct : r_err_ct + CNT_W'(1);
                        w_err_d    = 1'b1;
                    end
                    // Loss of lock wins over a window rollover on the same compare.
                    if (w_win_err_inc == EW'(LOSS_ERR)) begin
                        w_state_d     = SEARCH;
                        w_run_d       = '0;
                        w_lat_d       = r_lat + LW'(1);
                        w_relock_ct_d = (&r_relock_ct) ? r_relock_ct : r_relock_ct + 8'd1;
                        w_win_cnt_d   = '0;
                        w_win_err_d   = '0;
                    end else if (r_win_cnt == WW'(WIN - 1)) begin
                        w_win_cnt_d = '0;
                        w_win_err_d = '0;
                    end else begin
                        w_win_cnt_d = r_win_cnt + WW'(1);
                        w_win_err_d = w_win_err_inc;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        state_o     = r_state;
        locked_o    = (r_state == LOCKED);
        lat_o       = r_lat;
        bit_ct_o    = r_bit_ct;
        err_ct_o    = r_err_ct;
        relock_ct_o = r_relock_ct;
        err_o       = r_err;
    end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: a 32-bit and an 8-bit counter instance share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_viterbi_ber_checker;

    localparam int MAX_LAT  = 64;
    localparam int LOCK_RUN = 16;
    localparam int WIN      = 64;
    localparam int LOSS_ERR = 8;
    localparam int DLY      = 37;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       src_valid_i = 1'b0;
    logic       src_bit_i = 1'b0;
    logic       dec_valid_i = 1'b0;
    logic       dec_bit_i = 1'b0;
    logic       clear_i = 1'b0;

    logic [1:0]  state_o, state8;
    logic        locked_o, locked8;
    logic [5:0]  lat_o, lat8;
    logic [31:0] bit_ct_o, err_ct_o;
    logic [7:0]  bit_ct8, err_ct8;
    logic [7:0]  relock_ct_o, relock8;
    logic        err_o, err8;

    viterbi_ber_checker #(.CNT_W(32)) dut (
        .clk (clk), .rst (rst),
        .src_valid_i (src_valid_i), .src_bit_i (src_bit_i),
        .dec_valid_i (dec_valid_i), .dec_bit_i (dec_bit_i),
        .clear_i (clear_i),
        .state_o (state_o), .locked_o (locked_o), .lat_o (lat_o),
        .bit_ct_o (bit_ct_o), .err_ct_o (err_ct_o),
        .relock_ct_o (relock_ct_o), .err_o (err_o)
    );

    viterbi_ber_checker #(.CNT_W(8)) dut8 (
        .clk (clk), .rst (rst),
        .src_valid_i (src_valid_i), .src_bit_i (src_bit_i),
        .dec_valid_i (dec_valid_i), .dec_bit_i (dec_bit_i),
        .clear_i (clear_i),
        .state_o (state8), .locked_o (locked8), .lat_o (lat8),
        .bit_ct_o (bit_ct8), .err_ct_o (err_ct8),
        .relock_ct_o (relock8), .err_o (err8)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: raw (unbounded) counts; saturation applied at compare time.
    int     m_state, m_fill, m_lat, m_run, m_winc, m_wine;
    longint m_bit, m_err, m_relock;
    bit     m_errp;
    bit     m_hist[$];
    bit     m_chk = 1'b0;

    task automatic model_tick();
        bit ref_bit;
        bit do_cmp;
        if (rst) begin
            m_state = 0; m_fill = 0; m_lat = 0; m_run = 0; m_winc = 0; m_wine = 0;
            m_bit = 0; m_err = 0; m_relock = 0; m_errp = 0;
            m_hist.delete();
            for (int i = 0; i < MAX_LAT; i++) m_hist.push_back(1'b0);
            return;
        end
        m_errp  = 0;
        ref_bit = m_hist[m_lat];
        do_cmp  = dec_valid_i && !clear_i;
        if (clear_i) begin
            m_bit = 0; m_err = 0; m_relock = 0; m_winc = 0; m_wine = 0;
        end
        if (m_state == 0) begin
            if (src_valid_i) begin
                m_fill++;
                if (m_fill == MAX_LAT) begin
                    m_state = 1;
                    m_lat   = 0;
                end
            end
        end else if (m_state == 1) begin
            if (do_cmp) begin
                if (dec_bit_i == ref_bit) begin
                    m_run++;
                    if (m_run == LOCK_RUN) begin
                        m_state = 2; m_run = 0; m_winc = 0; m_wine = 0;
                    end
                end else begin
                    m_run = 0;
                    m_lat = (m_lat + 1) % MAX_LAT;
                end
            end
        end else begin
            if (do_cmp) begin
                m_bit++;
                if (dec_bit_i != ref_bit) begin
                    m_err++;
                    m_errp = 1;
                    m_wine++;
                end
                m_winc++;
                if (m_wine == LOSS_ERR) begin
                    m_state = 1; m_run = 0; m_lat = (m_lat + 1) % MAX_LAT;
                    m_relock++; m_winc = 0; m_wine = 0;
                end else if (m_winc == WIN) begin
                    m_winc = 0; m_wine = 0;
                end
            end
        end
        if (src_valid_i) begin
            m_hist.push_front(src_bit_i);
            void'(m_hist.pop_back());
        end
    endtask

    always @(negedge clk) begin
        if (m_chk) begin
            chk("state", state_o, m_state);
            chk("locked", locked_o, (m_state == 2) ? 1 : 0);
            chk("lat", lat_o, m_lat);
            chk("bit_ct", bit_ct_o, sat(m_bit, 32));
            chk("err_ct", err_ct_o, sat(m_err, 32));
            chk("relock_ct", relock_ct_o, sat(m_relock, 8));
            chk("err_o", err_o, m_errp);
            chk("state8", state8, m_state);
            chk("locked8", locked8, (m_state == 2) ? 1 : 0);
            chk("lat8", lat8, m_lat);
            chk("bit_ct8", bit_ct8, sat(m_bit, 8));
            chk("err_ct8", err_ct8, sat(m_err, 8));
            chk("relock8", relock8, sat(m_relock, 8));
            chk("err_o8", err8, m_errp);
        end
    end

    task automatic step(input bit sv, input bit sb, input bit dv, input bit db,
                        input bit clr, input bit r);
        src_valid_i = sv; src_bit_i = sb; dec_valid_i = dv; dec_bit_i = db;
        clear_i = clr; rst = r;
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    // Source stream: 31-bit LFSR; decoder output is the source delayed DLY pulses.
    logic [30:0] lfsr = 31'h1A2B3C4D;
    bit          src_log[$];
    int          cyc = 0;

    task automatic run_cycle(input bit inv, input bit clr, input bit r);
        bit sb;
        bit dv;
        bit db;
        lfsr = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
        sb = lfsr[0];
        src_log.push_back(sb);
        dv = (cyc >= DLY);
        db = dv ? (src_log[cyc - DLY] ^ inv) : 1'b0;
        step(1'b1, sb, dv, db, clr, r);
        cyc++;
    endtask

    task automatic wait_lock(input string name, input int budget);
        for (int i = 0; i < budget && !locked_o; i++) run_cycle(1'b0, 1'b0, 1'b0);
        chk(name, locked_o, 1);
    endtask

    initial begin
        longint b0;
        int     pulses;

        // Reset held two cycles with random inputs.
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        m_chk = 1'b1;
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        chk("rst_state", state_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_bit_ct", bit_ct_o, 0);
        chk("rst_err_ct", err_ct_o, 0);
        chk("rst_relock", relock_ct_o, 0);
        chk("rst_err_o", err_o, 0);

        // Fill, search, lock at D-1.
        wait_lock("lock_wait", 1000);
        chk("lock_lat", lat_o, DLY - 1);
        chk("lock_err_ct", err_ct_o, 0);
        b0 = longint'(bit_ct_o);
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0, 1'b0);
        chk("bit_ct_rate", bit_ct_o, b0 + 20);

        // Three isolated errors, no loss.
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            run_cycle((i % 10) == 0, 1'b0, 1'b0);
            if (err_o) pulses++;
        end
        chk("err3_ct", err_ct_o, 3);
        chk("err3_pulses", pulses, 3);
        chk("err3_locked", locked_o, 1);

        // Clear, then 8 errors in one window forces loss of lock.
        run_cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 1'b0, 1'b0);
            if (i == 6) chk("loss_pre_state", state_o, 2);
        end
        chk("loss_state", state_o, 1);
        chk("loss_relock", relock_ct_o, 1);
        chk("loss_err_ct", err_ct_o, 8);
        wait_lock("relock_wait", 1000);
        chk("relock_lat", lat_o, DLY - 1);
        chk("relock_err_kept", err_ct_o, 8);
        chk("relock_ct_kept", relock_ct_o, 1);

        // Clear in the same cycle as an error.
        run_cycle(1'b1, 1'b1, 1'b0);
        chk("clr_bit_ct", bit_ct_o, 0);
        chk("clr_err_ct", err_ct_o, 0);
        chk("clr_state", state_o, 2);

        // Saturation of the 8-bit instance.
        for (int i = 0; i < 300; i++) run_cycle(1'b0, 1'b0, 1'b0);
        chk("sat_bit_ct8", bit_ct8, 255);
        chk("sat_bit_ct32", bit_ct_o, 300);
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 1'b0);
        chk("sat_hold8", bit_ct8, 255);

        // Reset mid-stream, then the whole acquisition again.
        run_cycle(1'b0, 1'b0, 1'b1);
        chk("mrst_state", state_o, 0);
        chk("mrst_lat", lat_o, 0);
        chk("mrst_bit_ct", bit_ct_o, 0);
        chk("mrst_bit_ct8", bit_ct8, 0);
        chk("mrst_relock", relock_ct_o, 0);
        wait_lock("mrst_lock_wait", 1000);
        chk("mrst_lock_lat", lat_o, DLY - 1);

        m_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
